// File: rtl/conv_sum_ctrl.sv
// Multi-operand accumulator. Sums INPUT_NUM signed operands per beat over a job of cfg_len beats.
// Define CONV_SUM_SAT_EN to clamp the accumulator after every beat; otherwise it wraps modulo 2^WIDTH.
module conv_sum_ctrl #(
  parameter int WIDTH     = 32,
  parameter int INPUT_NUM = 4,
  parameter int LEN_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INPUT_NUM*WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy
);

  localparam int LOG2N = $clog2(INPUT_NUM);
`ifdef CONV_SUM_SAT_EN
  localparam int SUM_W = WIDTH + LOG2N;
  localparam int EXT_W = SUM_W + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`else
  // The wrapped result only depends on the low WIDTH bits, so the growth bits are never formed.
  localparam int SUM_W = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic [WIDTH-1:0]   acc_beat;

  logic signed [SUM_W-1:0] opnd_ext [INPUT_NUM];
  logic signed [SUM_W-1:0] beat_sum;

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_NUM; gi++) begin : g_opnd
      if (SUM_W > WIDTH) begin : g_sext
        assign opnd_ext[gi] = {{(SUM_W-WIDTH){in_data[gi*WIDTH+WIDTH-1]}}, in_data[gi*WIDTH +: WIDTH]};
      end else begin : g_plain
        assign opnd_ext[gi] = in_data[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      beat_sum = beat_sum + opnd_ext[i];
    end
  end

`ifdef CONV_SUM_SAT_EN
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] acc_sext;
  logic signed [EXT_W-1:0] beat_sext;

  always_comb begin
    acc_sext  = {{(EXT_W-WIDTH){acc_q[WIDTH-1]}}, acc_q};
    beat_sext = {beat_sum[SUM_W-1], beat_sum};
    acc_ext   = acc_sext + beat_sext;
    if (acc_ext > SAT_MAX) begin
      acc_beat = SAT_MAX[WIDTH-1:0];
    end else if (acc_ext < SAT_MIN) begin
      acc_beat = SAT_MIN[WIDTH-1:0];
    end else begin
      acc_beat = acc_ext[WIDTH-1:0];
    end
  end
`else
  assign acc_beat = acc_q + beat_sum;
`endif

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start && (cfg_len != '0)) begin
          len_d   = cfg_len;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_beat;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // The accumulator is frozen in DONE, so it doubles as the held result.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : '0;
  assign busy      = (state_q != IDLE);

endmodule
